vga_sync_gen: RTL and testbench

//   Generates the VGA raster timing that drives the LifeGame renderer and the board's VGA pins.

---
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running pixel/line counters with zero-skew
// registered sync pins, active-video flag and single-clock line/frame strobes.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  output logic [9:0] VGAx,
  output logic [9:0] VGAy,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       pix_ce,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > 1024 || H_TOTAL < 1) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL must be in 1..1024");
  end
  if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL must be in 1..1024");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_sync_gen: CLK_DIV must be >= 1");
  end

  localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       Y_FRAME  = 10'(V_ACTIVE - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0]      X_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]      HS_ON    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]      HS_OFF   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]      Y_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0]      VS_ON    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]      VS_OFF   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;
  logic             x_wrap;
  logic             y_wrap;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             active_nxt;
  logic             pix_ce_nxt;
  logic             line_nxt;
  logic             frame_nxt;

  always_comb begin
    div_nxt    = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    pix_ce_nxt = (div_nxt == DIV_LAST);
  end

  // Next beam position; syncs and strobes are derived from it so every
  // registered output lines up with the coordinates on the same edge.
  always_comb begin
    x_wrap = (VGAx == X_LAST);
    y_wrap = (VGAy == Y_LAST);
    x_nxt  = VGAx;
    y_nxt  = VGAy;
    if (pix_ce) begin
      if (x_wrap) begin
        x_nxt = '0;
        y_nxt = y_wrap ? '0 : VGAy + 10'd1;
      end else begin
        x_nxt = VGAx + 10'd1;
      end
    end
  end

  always_comb begin
    hsync_nxt  = ({1'b0, x_nxt} >= HS_ON && {1'b0, x_nxt} < HS_OFF) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt  = ({1'b0, y_nxt} >= VS_ON && {1'b0, y_nxt} < VS_OFF) ? SYNC_POL : ~SYNC_POL;
    active_nxt = ({1'b0, x_nxt} < X_ACT) && ({1'b0, y_nxt} < Y_ACT);
    line_nxt   = pix_ce && x_wrap;
    frame_nxt  = pix_ce && x_wrap && (VGAy == Y_FRAME);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div        <= '0;
      VGAx       <= '0;
      VGAy       <= '0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      active     <= 1'b1;
      pix_ce     <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div        <= div_nxt;
      VGAx       <= x_nxt;
      VGAy       <= y_nxt;
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
      active     <= active_nxt;
      pix_ce     <= pix_ce_nxt;
      line_tick  <= line_nxt;
      frame_tick <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: one full-size instance for horizontal timing,
// two reduced-raster instances (CLK_DIV 1 and 2) for vertical/frame timing.
module tb_vga_sync_gen;

  localparam int K_LINE = 0, K_ACTF = 1, K_HSF = 2, K_HSR = 3;
  localparam int K_FRAME = 4, K_VSF = 5, K_VSR = 6, K_WRAP = 7;

  typedef struct packed {
    int k;
    int x;
    int y;
    int a;
    int b;
    int c;
  } ev_t;

  logic clk;
  logic clr_a;
  logic clr_s[2];

  logic [9:0] x_a, y_a;
  logic hs_a, vs_a, act_a, pix_a, lt_a, ft_a;
  logic [9:0] sx[2], sy[2];
  logic shs[2], svs[2], sact[2], spix[2], slt[2], sft[2];

  ev_t qa[$];
  ev_t qb[$];
  ev_t qc[$];

  int checks = 0;
  int failures = 0;

  vga_sync_gen dut_a (
    .clk(clk), .clr(clr_a), .VGAx(x_a), .VGAy(y_a), .hsync(hs_a), .vsync(vs_a),
    .active(act_a), .pix_ce(pix_a), .line_tick(lt_a), .frame_tick(ft_a)
  );

  // Reduced raster: 20 px/line (hsync 12..14), 12 lines/frame (vsync 7..8)
  vga_sync_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .CLK_DIV(1)
  ) dut_s1 (
    .clk(clk), .clr(clr_s[0]), .VGAx(sx[0]), .VGAy(sy[0]), .hsync(shs[0]), .vsync(svs[0]),
    .active(sact[0]), .pix_ce(spix[0]), .line_tick(slt[0]), .frame_tick(sft[0])
  );

  vga_sync_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .CLK_DIV(2)
  ) dut_s2 (
    .clk(clk), .clr(clr_s[1]), .VGAx(sx[1]), .VGAy(sy[1]), .hsync(shs[1]), .vsync(svs[1]),
    .active(sact[1]), .pix_ce(spix[1]), .line_tick(slt[1]), .frame_tick(sft[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string kname(input int k);
    case (k)
      K_LINE:  return "line_tick";
      K_ACTF:  return "active_fall";
      K_HSF:   return "hsync_fall";
      K_HSR:   return "hsync_rise";
      K_FRAME: return "frame_tick";
      K_VSF:   return "vsync_fall";
      K_VSR:   return "vsync_rise";
      K_WRAP:  return "raster_wrap";
      default: return "unknown";
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic push(input int d, input int k, input int x, input int y,
                      input int a, input int b, input int c);
    ev_t e;
    e = '{k: k, x: x, y: y, a: a, b: b, c: c};
    case (d)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic observe(input int d, input ev_t g);
    ev_t e;
    checks++;
    if (qsize(d) == 0) begin
      failures++;
      $display("FAIL dut%0d unexpected %s at (%0d,%0d) a=%0d b=%0d c=%0d, required none",
               d, kname(g.k), g.x, g.y, g.a, g.b, g.c);
      return;
    end
    case (d)
      0:       e = qa.pop_front();
      1:       e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
    if (g != e) begin
      failures++;
      $display("FAIL dut%0d %s: got (%0d,%0d) a=%0d b=%0d c=%0d, required %s (%0d,%0d) a=%0d b=%0d c=%0d",
               d, kname(g.k), g.x, g.y, g.a, g.b, g.c, kname(e.k), e.x, e.y, e.a, e.b, e.c);
    end
  endtask

  task automatic tick_w(input logic t, inout int w, input string nm);
    if (t) begin
      w++;
    end else if (w != 0) begin
      checks++;
      if (w != 1) begin
        failures++;
        $display("FAIL %s got=%0d required=1", nm, w);
      end
      w = 0;
    end
  endtask

  // Monitor: full-size instance
  int rel_a, llt_a, pc_a, hsf_a, ltw_a;
  logic phs_a, pact_a, pvs_a;
  initial begin
    forever begin
      @(negedge clk);
      if (clr_a) begin
        rel_a = 0; llt_a = 0; pc_a = 0; hsf_a = 0; ltw_a = 0;
        phs_a = 1'b1; pact_a = 1'b1; pvs_a = 1'b1;
      end else begin
        rel_a++;
        if (pix_a) pc_a++;
        if (lt_a) begin
          observe(0, '{K_LINE, int'(x_a), int'(y_a), rel_a - llt_a, int'(act_a), pc_a});
          llt_a = rel_a;
          pc_a = 0;
        end
        if (ft_a) observe(0, '{K_FRAME, int'(x_a), int'(y_a), 0, 0, 0});
        if (pact_a && !act_a) observe(0, '{K_ACTF, int'(x_a), int'(y_a), 0, 0, 0});
        if (phs_a && !hs_a) begin
          observe(0, '{K_HSF, int'(x_a), int'(y_a), 0, 0, 0});
          hsf_a = rel_a;
        end
        if (!phs_a && hs_a) observe(0, '{K_HSR, int'(x_a), int'(y_a), rel_a - hsf_a, 0, 0});
        if (pvs_a != vs_a) observe(0, '{vs_a ? K_VSR : K_VSF, int'(x_a), int'(y_a), 0, 0, 0});
        tick_w(lt_a, ltw_a, "dut0 line_tick_width");
        phs_a = hs_a; pact_a = act_a; pvs_a = vs_a;
      end
    end
  end

  // Monitor: reduced-raster instances
  int rel_s[2], lfr_s[2], pc_s[2], vsf_s[2], ltw_s[2], ftw_s[2];
  logic pvs_s[2];
  logic [9:0] px_s[2], py_s[2];
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (clr_s[i]) begin
          rel_s[i] = 0; lfr_s[i] = 0; pc_s[i] = 0; vsf_s[i] = 0; ltw_s[i] = 0; ftw_s[i] = 0;
          pvs_s[i] = 1'b1; px_s[i] = '0; py_s[i] = '0;
        end else begin
          rel_s[i]++;
          if (spix[i]) pc_s[i]++;
          if (sft[i]) begin
            observe(i + 1, '{K_FRAME, int'(sx[i]), int'(sy[i]), rel_s[i] - lfr_s[i], pc_s[i], 0});
            lfr_s[i] = rel_s[i];
            pc_s[i] = 0;
          end
          if (pvs_s[i] && !svs[i]) begin
            observe(i + 1, '{K_VSF, int'(sx[i]), int'(sy[i]), 0, 0, 0});
            vsf_s[i] = rel_s[i];
          end
          if (!pvs_s[i] && svs[i])
            observe(i + 1, '{K_VSR, int'(sx[i]), int'(sy[i]), rel_s[i] - vsf_s[i], 0, 0});
          if (px_s[i] == 10'd19 && py_s[i] == 10'd11 && sx[i] == 10'd0 && sy[i] == 10'd0)
            observe(i + 1, '{K_WRAP, 0, 0, int'({slt[i], sact[i], svs[i]}), 0, 0});
          tick_w(slt[i], ltw_s[i], "small line_tick_width");
          tick_w(sft[i], ftw_s[i], "small frame_tick_width");
          pvs_s[i] = svs[i]; px_s[i] = sx[i]; py_s[i] = sy[i];
        end
      end
    end
  end

  task automatic check_rst(input int d);
    logic [25:0] got;
    case (d)
      0:       got = {x_a, y_a, hs_a, vs_a, act_a, pix_a, lt_a, ft_a};
      1:       got = {sx[0], sy[0], shs[0], svs[0], sact[0], spix[0], slt[0], sft[0]};
      default: got = {sx[1], sy[1], shs[1], svs[1], sact[1], spix[1], slt[1], sft[1]};
    endcase
    checks++;
    if (got != {10'd0, 10'd0, 3'b111, 3'b000}) begin
      failures++;
      $display("FAIL dut%0d reset_state got x=%0d y=%0d hs/vs/act/pix/lt/ft=%b required x=0 y=0 111000",
               d, got[25:16], got[15:6], got[5:0]);
    end
  endtask

  task automatic wait_drain(input int d, input int budget);
    for (int i = 0; i < budget && qsize(d) != 0; i++) @(negedge clk);
    checks++;
    if (qsize(d) != 0) begin
      failures++;
      $display("FAIL dut%0d drain: pending events=%0d required 0 within %0d clk", d, qsize(d), budget);
    end
  endtask

  task automatic wait_pos(input int d, input int x, input int y, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (d == 0) hit = (int'(x_a) == x && int'(y_a) == y);
      else        hit = (int'(sx[d-1]) == x && int'(sy[d-1]) == y);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL dut%0d reach_position: not reached, required (%0d,%0d) within %0d clk", d, x, y, budget);
    end
  endtask

  // Full-size line y: active falls at 640, hsync low 656..751, wrap to (0,y+1)
  task automatic push_line(input int y, input int per);
    push(0, K_ACTF, 640, y, 0, 0, 0);
    push(0, K_HSF, 656, y, 0, 0, 0);
    push(0, K_HSR, 752, y, 96, 0, 0);
    push(0, K_LINE, 0, y + 1, per, 1, per);
  endtask

  // Reduced frame; per/pc are cycles and pix_ce pulses since the previous frame_tick or release
  task automatic push_frame(input int d, input int per, input int pc, input int vsw);
    push(d, K_FRAME, 0, 6, per, pc, 0);
    push(d, K_VSF, 0, 7, 0, 0, 0);
    push(d, K_VSR, 0, 9, vsw, 0, 0);
    push(d, K_WRAP, 0, 0, 7, 0, 0);
  endtask

  initial begin
    clr_a = 1'b0;
    clr_s[0] = 1'b0;
    clr_s[1] = 1'b0;
    #1;
    clr_a = 1'b1;
    clr_s[0] = 1'b1;
    clr_s[1] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) check_rst(d);
    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++) check_rst(d);

    // Full-size horizontal timing: first line_tick 801 clk after release, then 800
    push_line(0, 801);
    push_line(1, 800);
    push_line(2, 800);
    @(negedge clk);
    #1 clr_a = 1'b0;
    wait_drain(0, 3000);

    // Async reset mid-line, held 5 clk, then restart from (0,0)
    wait_pos(0, 300, 3, 1000);
    #1 clr_a = 1'b1;
    #1 check_rst(0);
    repeat (5) begin
      @(negedge clk);
      check_rst(0);
    end
    push_line(0, 801);
    #1 clr_a = 1'b0;
    wait_drain(0, 1000);
    #1 clr_a = 1'b1;

    // Reduced rasters: CLK_DIV=1 frame 240 clk, CLK_DIV=2 frame 480 clk
    push_frame(1, 121, 121, 40);
    push_frame(1, 240, 240, 40);
    push_frame(2, 240, 120, 80);
    push_frame(2, 480, 240, 80);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 clr_s[i] = 1'b0;
      wait_drain(i + 1, 1200);
      wait_pos(i + 1, 8, 3, 1000);
      #1 clr_s[i] = 1'b1;
      #1 check_rst(i + 1);
      repeat (3) begin
        @(negedge clk);
        check_rst(i + 1);
      end
      if (i == 0) push_frame(1, 121, 121, 40);
      else        push_frame(2, 240, 120, 80);
      #1 clr_s[i] = 1'b0;
      wait_drain(i + 1, 700);
      #1 clr_s[i] = 1'b1;
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
